// File: rtl/timer_device_if.sv
// System bus interface: single clock, one-wait-state request/ready handshake, level irq.
interface Bus;
  logic        clk;
  logic        reset;
  logic        valid;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        irq;

  modport s (
    input  clk, reset, valid, address, wstrobe, wdata,
    output ready, rdata, irq
  );

  modport m (
    input  clk, ready, rdata, irq,
    output reset, valid, address, wstrobe, wdata
  );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped down-counting timer with one-shot/periodic modes and level irq.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_device #(
  parameter logic [31:0] RESET_RELOAD   = 32'd0,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  Bus.s bus
);

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

  bus_state_t  state;
  bus_state_t  state_next;

  logic        enable;
  logic        periodic;
  logic        irq_enable;
  logic [31:0] reload;
  logic [31:0] count;
  logic        expired;
  logic        irq;
  logic [31:0] rdata;

  logic        read_access;
  logic        write_commit;
  logic [2:0]  offset;
  logic        wr_ctrl;
  logic        wr_reload;
  logic        wr_count;
  logic        wr_status;
  logic        wr_prescale;
  logic        tick;
  logic        expire;
  logic [31:0] prescale_ext;
  logic [31:0] read_mux;
  logic        unused_addr;

  function automatic logic [31:0] write_into(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic clear_into(input logic        cur,
                                      input logic [31:0] wd,
                                      input logic [3:0]  strb);
    return cur & ~(strb[0] & wd[0]);
  endfunction

  assign offset      = bus.address[4:2];
  assign unused_addr = ^{bus.address[31:5], bus.address[1:0]};

  // Handshake FSM
  always_ff @(posedge bus.clk) begin
    if (bus.reset) state <= BUS_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next   = BUS_IDLE;
    read_access  = 1'b0;
    write_commit = 1'b0;
    unique case (state)
      BUS_IDLE: begin
        if (bus.valid) begin
          state_next  = BUS_ACK;
          read_access = 1'b1;
        end
      end
      BUS_ACK: begin
        state_next   = BUS_IDLE;
        write_commit = bus.valid && (bus.wstrobe != 4'b0000);
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  assign bus.ready = (state == BUS_ACK);
  assign bus.rdata = rdata;
  assign bus.irq   = irq;

  assign wr_ctrl     = write_commit && (offset == 3'd0);
  assign wr_reload   = write_commit && (offset == 3'd1);
  assign wr_count    = write_commit && (offset == 3'd2);
  assign wr_status   = write_commit && (offset == 3'd3);
  assign wr_prescale = write_commit && (offset == 3'd4);

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pcnt;

  assign prescale_ext = 32'(prescale);
  assign tick         = enable && (pcnt == prescale);

  always_ff @(posedge bus.clk) begin
    if (bus.reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (!enable || tick) pcnt <= '0;
      else                 pcnt <= pcnt + PRESCALE_WIDTH'(1);
      if (wr_prescale)
        prescale <= PRESCALE_WIDTH'(write_into(prescale_ext, bus.wdata, bus.wstrobe));
    end
  end
`else
  localparam int unsigned unused_prescale_width = PRESCALE_WIDTH;
  logic unused_wr_prescale;

  assign unused_wr_prescale = wr_prescale;
  assign prescale_ext       = '0;
  assign tick               = enable;
`endif

  assign expire = tick && (count == 32'd0);

  always_comb begin
    read_mux = '0;
    unique case (offset)
      3'd0:    read_mux = {29'd0, irq_enable, periodic, enable};
      3'd1:    read_mux = reload;
      3'd2:    read_mux = count;
      3'd3:    read_mux = {31'd0, expired};
      3'd4:    read_mux = prescale_ext;
      default: read_mux = '0;
    endcase
  end

  // Bus writes are assigned after the tick update so they override it on the same edge.
  always_ff @(posedge bus.clk) begin
    if (bus.reset) begin
      enable     <= 1'b0;
      periodic   <= 1'b0;
      irq_enable <= 1'b0;
      reload     <= RESET_RELOAD;
      count      <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
      rdata      <= '0;
    end else begin
      irq   <= expired && irq_enable;
      rdata <= read_access ? read_mux : '0;

      if (tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (periodic)  count <= reload;
        else                enable <= 1'b0;
      end

      if (wr_ctrl)
        {irq_enable, periodic, enable} <= 3'(write_into({29'd0, irq_enable, periodic, enable},
                                                        bus.wdata, bus.wstrobe));
      if (wr_reload) reload <= write_into(reload, bus.wdata, bus.wstrobe);
      if (wr_count)  count  <= write_into(count, bus.wdata, bus.wstrobe);

      if (expire)         expired <= 1'b1;
      else if (wr_status) expired <= clear_into(expired, bus.wdata, bus.wstrobe);
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: per-cycle reference model plus hand-computed checks.
module tb_timer_device;

  localparam logic [31:0] RST_RELOAD = 32'h1234_5678;
  localparam int unsigned PW         = 8;
  localparam logic [31:0] PMASK      = (PW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PW) - 32'd1);
`ifdef TIMER_PRESCALER_EN
  localparam bit HAS_PRE = 1'b1;
`else
  localparam bit HAS_PRE = 1'b0;
`endif

  Bus bus();

  timer_device #(
    .RESET_RELOAD   (RST_RELOAD),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .bus (bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  // Reference model: register file as an array, updated once per clock from the rules.
  logic [31:0] m_reg [8];
  logic        m_ready = 1'b0;
  logic        m_irq   = 1'b0;
  logic [31:0] m_rdata = '0;
  int unsigned m_pc    = 0;
  bit          m_live  = 1'b0;

  always @(posedge bus.clk) begin : model
    logic [31:0] cur [8];
    logic [31:0] nxt [8];
    logic [31:0] merged;
    logic        tick;
    logic        expire;
    int unsigned off;
    if (bus.reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_reg[1] = RST_RELOAD;
      m_ready  = 1'b0;
      m_rdata  = '0;
      m_irq    = 1'b0;
      m_pc     = 0;
      m_live   = 1'b1;
    end else if (m_live) begin
      cur    = m_reg;
      nxt    = m_reg;
      off    = int'(bus.address[4:2]);
      m_irq  = cur[3][0] && cur[0][2];
      tick   = cur[0][0] && (!HAS_PRE || m_pc == cur[4]);
      expire = tick && (cur[2] == 0);
      if (tick) begin
        if (cur[2] != 0)    nxt[2] = cur[2] - 1;
        else if (cur[0][1]) nxt[2] = cur[1];
        else                nxt[0][0] = 1'b0;
      end
      m_pc = (!cur[0][0] || tick) ? 0 : m_pc + 1;
      if (bus.valid && m_ready && bus.wstrobe != 4'b0000) begin
        merged = cur[off];
        for (int b = 0; b < 4; b++)
          if (bus.wstrobe[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
        case (off)
          0: nxt[0] = merged & 32'h7;
          1: nxt[1] = merged;
          2: nxt[2] = merged;
          3: if (bus.wstrobe[0] && bus.wdata[0]) nxt[3] = '0;
          4: if (HAS_PRE) nxt[4] = merged & PMASK;
          default: ;
        endcase
      end
      if (expire) nxt[3] = 32'd1;
      m_rdata = (bus.valid && !m_ready) ? cur[off] : '0;
      m_ready = bus.valid && !m_ready;
      m_reg   = nxt;
    end
  end

  always @(negedge bus.clk) begin
    if (m_live) begin
      check("ready", {31'd0, bus.ready}, {31'd0, m_ready});
      check("rdata", bus.rdata, m_rdata);
      check("irq",   {31'd0, bus.irq},   {31'd0, m_irq});
    end
  end

  // Called on a negedge; returns on the negedge after the committing edge.
  task automatic access(input logic [2:0] off, input logic [3:0] strb,
                        input logic [31:0] wd, output logic [31:0] rd);
    int unsigned n;
    bus.valid   = 1'b1;
    bus.address = 32'h4000_1000 | {27'd0, off, 2'b00};
    bus.wstrobe = strb;
    bus.wdata   = wd;
    n = 0;
    do begin
      @(negedge bus.clk);
      n++;
    end while (!bus.ready && n < 10);
    check("handshake", {31'd0, bus.ready}, 32'd1);
    rd = bus.rdata;
    @(negedge bus.clk);
    bus.valid   = 1'b0;
    bus.wstrobe = 4'b0000;
  endtask

  task automatic wr(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] dummy;
    access(off, strb, wd, dummy);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    access(off, 4'b0000, 32'hFFFF_FFFF, d);
  endtask

  task automatic wait_irq(input int unsigned limit, output int unsigned k);
    k = 0;
    do begin
      @(negedge bus.clk);
      k++;
    end while (!bus.irq && k < limit);
  endtask

  task automatic quiesce();
    wr(3'd0, 4'hF, 32'd0);
    wr(3'd3, 4'hF, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int unsigned k;
    bus.reset   = 1'b1;
    bus.valid   = 1'b0;
    bus.address = '0;
    bus.wstrobe = '0;
    bus.wdata   = '0;
    repeat (3) @(negedge bus.clk);
    bus.reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      check($sformatf("reset_reg%0d", i), d, (i == 1) ? RST_RELOAD : 32'd0);
    end

    // One-shot: expiry 4 edges after enable, irq one edge later
    wr(3'd2, 4'hF, 32'd3);
    wr(3'd0, 4'hF, 32'd5);
    wait_irq(40, k);
    check("oneshot_latency", k, 32'd5);
    rd(3'd3, d); check("oneshot_status", d, 32'd1);
    rd(3'd0, d); check("oneshot_ctrl", d, 32'd4);
    rd(3'd2, d); check("oneshot_count", d, 32'd0);
    quiesce();
    rd(3'd3, d); check("status_cleared", d, 32'd0);

    // Periodic: expiries every 3 edges; first W1C lands on an expiry edge
    wr(3'd1, 4'hF, 32'd2);
    wr(3'd2, 4'hF, 32'd2);
    wr(3'd0, 4'hF, 32'd7);
    wait_irq(40, k);
    check("periodic_first", k, 32'd4);
    wr(3'd3, 4'hF, 32'd1);
    rd(3'd3, d); check("clear_vs_expiry", d, 32'd1);
    wr(3'd3, 4'hF, 32'd1);
    @(negedge bus.clk);
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);
    wait_irq(40, k);
    check("periodic_again", k, 32'd2);
    quiesce();

    // Byte strobes
    wr(3'd1, 4'hF, 32'hAABB_CCDD);
    wr(3'd1, 4'b0010, 32'h0000_1100);
    rd(3'd1, d); check("strobe_byte1", d, 32'hAABB_11DD);
    wr(3'd1, 4'b1000, 32'h7700_0000);
    rd(3'd1, d); check("strobe_byte3", d, 32'h77BB_11DD);
    wr(3'd0, 4'b0010, 32'hFFFF_FFFF);
    rd(3'd0, d); check("ctrl_upper_byte", d, 32'd0);

    // Prescaler
`ifdef TIMER_PRESCALER_EN
    wr(3'd4, 4'hF, 32'hFFFF_FFFF);
    rd(3'd4, d); check("prescale_width", d, 32'h0000_00FF);
    wr(3'd4, 4'hF, 32'd3);
    rd(3'd4, d); check("prescale_read", d, 32'd3);
    wr(3'd2, 4'hF, 32'd1);
    wr(3'd0, 4'hF, 32'd5);
    wait_irq(60, k);
    check("prescale_latency", k, 32'd9);
`else
    wr(3'd4, 4'hF, 32'd3);
    rd(3'd4, d); check("prescale_absent", d, 32'd0);
    wr(3'd2, 4'hF, 32'd1);
    wr(3'd0, 4'hF, 32'd5);
    wait_irq(60, k);
    check("noprescale_latency", k, 32'd3);
`endif
    quiesce();

    // Unmapped offsets
    wr(3'd6, 4'hF, 32'hFFFF_FFFF);
    rd(3'd6, d); check("offset6", d, 32'd0);

    // Reset while a write is held
    bus.valid   = 1'b1;
    bus.address = 32'h4000_1004;
    bus.wstrobe = 4'hF;
    bus.wdata   = 32'hDEAD_BEEF;
    @(negedge bus.clk);
    check("midwrite_ready", {31'd0, bus.ready}, 32'd1);
    bus.reset = 1'b1;
    @(negedge bus.clk);
    check("reset_drops_ready", {31'd0, bus.ready}, 32'd0);
    bus.reset   = 1'b0;
    bus.valid   = 1'b0;
    bus.wstrobe = 4'b0000;
    @(negedge bus.clk);
    rd(3'd1, d); check("reset_no_commit", d, RST_RELOAD);
    rd(3'd0, d); check("reset_ctrl", d, 32'd0);
    rd(3'd2, d); check("reset_count", d, 32'd0);

    @(negedge bus.clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
